// File: rtl/tx_beamformer_pkg.sv
// Shared types, widths and the Q2.30 -> Q1.15 saturating narrow used by
// the transmit beamformer.
package tx_bf_pkg;
    localparam int DW        = 16;
    localparam int PW        = 33;
    localparam int FRAME_LEN = 8;
    localparam int N_ANT     = 4;
    localparam int CW        = $clog2(FRAME_LEN);
    localparam int AW        = $clog2(N_ANT);

    localparam logic signed [DW-1:0] W_DEF_RE = 16'sh4000;
    localparam logic signed [DW-1:0] W_DEF_IM = '0;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // Bits [32:30] disagreeing means the Q2.30 value is outside Q1.15 range.
    function automatic logic signed [DW-1:0] sat_q15(input logic signed [PW-1:0] v);
        if (&v[PW-1:PW-3] || ~|v[PW-1:PW-3])
            return v[2*DW-2:DW-1];
        return v[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction
endpackage

// File: rtl/tx_beamformer_if.sv
// Symbol, weight-programming and per-antenna output bundle.
interface tx_beamformer_if;
    import tx_bf_pkg::*;

    logic signed [DW-1:0] din_r, din_i;
    logic                 din_valid;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic signed [DW-1:0] w_re, w_im;
    logic                 w_commit;
    logic                 frame;
    logic signed [DW-1:0] y1r, y1i, y2r, y2i, y3r, y3i, y4r, y4i;
    logic                 dout_valid;

    modport master (
        output din_r, din_i, din_valid, w_we, w_addr, w_re, w_im, w_commit,
        input  frame, y1r, y1i, y2r, y2i, y3r, y3i, y4r, y4i, dout_valid
    );
    modport slave (
        input  din_r, din_i, din_valid, w_we, w_addr, w_re, w_im, w_commit,
        output frame, y1r, y1i, y2r, y2i, y3r, y3i, y4r, y4i, dout_valid
    );
endinterface

// File: rtl/tx_beamformer_cmult_sat.sv
// Registered complex multiply p = w * s with Q1.15 saturation.
module cmult_sat
    import tx_bf_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  cplx_t w,
    input  cplx_t s,
    output cplx_t p
);
    logic signed [PW-1:0] wr, wi, sr, si, re_sum, im_sum;

    assign wr = {{(PW-DW){w.re[DW-1]}}, w.re};
    assign wi = {{(PW-DW){w.im[DW-1]}}, w.im};
    assign sr = {{(PW-DW){s.re[DW-1]}}, s.re};
    assign si = {{(PW-DW){s.im[DW-1]}}, s.im};

    assign re_sum = wr * sr - wi * si;
    assign im_sum = wr * si + wi * sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) p <= '0;
        else      p <= '{re: sat_q15(re_sum), im: sat_q15(im_sum)};
    end
endmodule

// File: rtl/tx_beamformer.sv
// Transmit beamformer: one symbol per 8-clock frame, four weighted copies
// produced by a single time-shared complex multiplier.
module tx_beamformer
    import tx_bf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    tx_beamformer_if.slave bus
);
    localparam cplx_t W_DEF = '{re: W_DEF_RE, im: W_DEF_IM};

    logic [CW-1:0]     count;
    cplx_t             s;
    logic              s_v;
    cplx_t [N_ANT-1:0] shadow, shadow_nxt, active, stage, y;
    logic              pending, commit_now, dv;
    logic [AW-1:0]     mul_ch, stg_ch;
    cplx_t             w_sel, prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else      count <= count + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s   <= '0;
            s_v <= 1'b0;
        end else if (count == '0) begin
            s   <= '{re: bus.din_r, im: bus.din_i};
            s_v <= bus.din_valid;
        end
    end

    // A write landing on the copy edge must reach the active bank too.
    always_comb begin
        shadow_nxt = shadow;
        if (bus.w_we) shadow_nxt[bus.w_addr] = '{re: bus.w_re, im: bus.w_im};
    end

    assign commit_now = (count == '0) && (pending || bus.w_commit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow  <= {N_ANT{W_DEF}};
            active  <= {N_ANT{W_DEF}};
            pending <= 1'b0;
        end else begin
            shadow  <= shadow_nxt;
            if (commit_now) active <= shadow_nxt;
            pending <= !commit_now && (pending || bus.w_commit);
        end
    end

    // Channel k is presented in count k+1, its product lands one edge later.
    assign mul_ch = AW'(count - CW'(1));
    assign stg_ch = AW'(count - CW'(2));
    assign w_sel  = active[mul_ch];

    cmult_sat u_mul (
        .clk (clk),
        .rst (rst),
        .w   (w_sel),
        .s   (s),
        .p   (prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= '0;
            y     <= '0;
            dv    <= 1'b0;
        end else begin
            if (count >= CW'(2) && count <= CW'(5)) stage[stg_ch] <= prod;
            dv <= 1'b0;
            if (count == CW'(6)) begin
                dv <= s_v;
                if (s_v) y <= stage;
            end
        end
    end

    assign bus.frame      = rst && (count == '0);
    assign bus.dout_valid = dv;
    assign bus.y1r = y[0].re;
    assign bus.y1i = y[0].im;
    assign bus.y2r = y[1].re;
    assign bus.y2i = y[1].im;
    assign bus.y3r = y[2].re;
    assign bus.y3i = y[2].im;
    assign bus.y4r = y[3].re;
    assign bus.y4i = y[3].im;
endmodule

// File: tb/tb_tx_beamformer.sv
// Bench for tx_beamformer: constant vector table, random traffic against a
// frame-level reference model, and hand-written commit/hold/reset sequences.
module tb_tx_beamformer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tx_beamformer_if bus();

    tx_beamformer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    logic [15:0] yr [4];
    logic [15:0] yi [4];
    assign yr[0] = bus.y1r;  assign yi[0] = bus.y1i;
    assign yr[1] = bus.y2r;  assign yi[1] = bus.y2i;
    assign yr[2] = bus.y3r;  assign yi[2] = bus.y3i;
    assign yr[3] = bus.y4r;  assign yi[3] = bus.y4i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: Q2.30 product sum narrowed to Q1.15 by plain arithmetic.
    function automatic logic [15:0] q15(input longint v);
        longint lim = 64'sd1073741824;
        if (v >= lim)  return 16'h7FFF;
        if (v < -lim)  return 16'h8000;
        return 16'(v >>> 15);
    endfunction

    function automatic logic [31:0] cmul(input logic [15:0] wr, input logic [15:0] wi,
                                         input logic [15:0] sr, input logic [15:0] si);
        longint a = longint'($signed(wr));
        longint b = longint'($signed(wi));
        longint c = longint'($signed(sr));
        longint d = longint'($signed(si));
        return {q15(a * c - b * d), q15(a * d + b * c)};
    endfunction

    // Frame-level model: the whole output set is computed at the sampling edge
    // and released six edges later.
    int          m_cnt;
    logic        m_pend, m_nv, m_dv;
    logic [15:0] m_shr[4], m_shi[4], m_acr[4], m_aci[4];
    logic [15:0] m_nr[4], m_ni[4], m_yr[4], m_yi[4];
    logic [15:0] sh_r_n[4], sh_i_n[4], use_r[4], use_i[4];
    logic        commit_now;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            sh_r_n[k] = m_shr[k];
            sh_i_n[k] = m_shi[k];
        end
        if (bus.w_we === 1'b1) begin
            sh_r_n[bus.w_addr] = bus.w_re;
            sh_i_n[bus.w_addr] = bus.w_im;
        end
        commit_now = (m_cnt == 0) && (m_pend || bus.w_commit === 1'b1);
        for (int k = 0; k < 4; k++) begin
            use_r[k] = commit_now ? sh_r_n[k] : m_acr[k];
            use_i[k] = commit_now ? sh_i_n[k] : m_aci[k];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  <= 0;
            m_pend <= 1'b0;
            m_nv   <= 1'b0;
            m_dv   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_shr[k] <= 16'h4000; m_shi[k] <= 16'h0000;
                m_acr[k] <= 16'h4000; m_aci[k] <= 16'h0000;
                m_nr[k]  <= '0;       m_ni[k]  <= '0;
                m_yr[k]  <= '0;       m_yi[k]  <= '0;
            end
        end else begin
            m_cnt  <= (m_cnt + 1) % 8;
            m_pend <= commit_now ? 1'b0 : (m_pend || bus.w_commit === 1'b1);
            for (int k = 0; k < 4; k++) begin
                m_shr[k] <= sh_r_n[k];
                m_shi[k] <= sh_i_n[k];
                if (commit_now) begin
                    m_acr[k] <= sh_r_n[k];
                    m_aci[k] <= sh_i_n[k];
                end
                if (m_cnt == 0)
                    {m_nr[k], m_ni[k]} <= cmul(use_r[k], use_i[k], bus.din_r, bus.din_i);
                if (m_cnt == 6 && m_nv) begin
                    m_yr[k] <= m_nr[k];
                    m_yi[k] <= m_ni[k];
                end
            end
            if (m_cnt == 0) m_nv <= bus.din_valid;
            m_dv <= (m_cnt == 6) && m_nv;
        end
    end

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            check("frame", 32'(bus.frame), 32'(rst && m_cnt == 0));
            check("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("y%0dr", k + 1), 32'(yr[k]), 32'(m_yr[k]));
                check($sformatf("y%0di", k + 1), 32'(yi[k]), 32'(m_yi[k]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.din_valid = 1'b0;
        bus.w_we      = 1'b0;
        bus.w_commit  = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        check("rst dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst frame", 32'(bus.frame), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst y%0dr", k + 1), 32'(yr[k]), 32'd0);
            check($sformatf("rst y%0di", k + 1), 32'(yi[k]), 32'd0);
        end
        tick();
    endtask

    task automatic wait_dv(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.dout_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check("dout_valid timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cnt(input int c);
        logic ok = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (m_cnt == c) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("count align timeout", 32'd0, 32'd1);
    endtask

    typedef struct packed {
        logic [15:0]       sr, si;
        logic              wr_en;
        logic [1:0]        addr;
        logic [15:0]       wre, wim;
        logic [3:0][15:0]  er, ei;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] pick16();
        case ($urandom_range(3))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat, dv_cnt;

        // expected lanes listed {y4, y3, y2, y1}
        vecs[0] = '{sr:16'h4000, si:16'h0000, wr_en:1'b0, addr:2'd0, wre:16'h0000, wim:16'h0000,
                    er:{16'h2000, 16'h2000, 16'h2000, 16'h2000}, ei:{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[1] = '{sr:16'h4000, si:16'h0000, wr_en:1'b1, addr:2'd1, wre:16'h0000, wim:16'h4000,
                    er:{16'h2000, 16'h2000, 16'h0000, 16'h2000}, ei:{16'h0000, 16'h0000, 16'h2000, 16'h0000}};
        vecs[2] = '{sr:16'h8000, si:16'h0000, wr_en:1'b1, addr:2'd0, wre:16'h8000, wim:16'h0000,
                    er:{16'hC000, 16'hC000, 16'hC000, 16'h7FFF}, ei:{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[3] = '{sr:16'h7FFF, si:16'h7FFF, wr_en:1'b1, addr:2'd2, wre:16'h7FFF, wim:16'h7FFF,
                    er:{16'h3FFF, 16'h0000, 16'h3FFF, 16'h3FFF}, ei:{16'h3FFF, 16'h7FFF, 16'h3FFF, 16'h3FFF}};
        vecs[4] = '{sr:16'h1234, si:16'hF000, wr_en:1'b1, addr:2'd3, wre:16'h8000, wim:16'h8000,
                    er:{16'hDDCC, 16'h091A, 16'h091A, 16'h091A}, ei:{16'hFDCC, 16'hF800, 16'hF800, 16'hF800}};
        vecs[5] = '{sr:16'h7FFF, si:16'h7FFF, wr_en:1'b1, addr:2'd0, wre:16'h8000, wim:16'h7FFF,
                    er:{16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h8000}, ei:{16'h3FFF, 16'h3FFF, 16'h3FFF, 16'hFFFF}};

        bus.din_r = '0; bus.din_i = '0; bus.w_addr = '0; bus.w_re = '0; bus.w_im = '0;
        idle_inputs();
        tick();
        mon_en = 1'b1;

        // Each vector starts from reset weights; write+commit land on the
        // first sampling edge, which exercises write-through.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            rst           = 1'b1;
            bus.din_r     = vecs[v].sr;
            bus.din_i     = vecs[v].si;
            bus.din_valid = 1'b1;
            bus.w_we      = vecs[v].wr_en;
            bus.w_commit  = vecs[v].wr_en;
            bus.w_addr    = vecs[v].addr;
            bus.w_re      = vecs[v].wre;
            bus.w_im      = vecs[v].wim;
            tick();
            idle_inputs();
            wait_dv(lat);
            check($sformatf("vec%0d latency", v), 32'(lat + 1), 32'd7);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("vec%0d y%0dr", v, k + 1), 32'(yr[k]), 32'(vecs[v].er[k]));
                check($sformatf("vec%0d y%0di", v, k + 1), 32'(yi[k]), 32'(vecs[v].ei[k]));
            end
        end

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        rst = 1'b1;
        for (int c = 0; c < 800; c++) begin
            bus.din_r     = pick16();
            bus.din_i     = pick16();
            bus.din_valid = ($urandom_range(3) != 0);
            bus.w_we      = ($urandom_range(2) == 0);
            bus.w_addr    = 2'($urandom_range(3));
            bus.w_re      = pick16();
            bus.w_im      = pick16();
            bus.w_commit  = ($urandom_range(9) == 0);
            tick();
        end
        idle_inputs();

        // Commit issued mid-frame: current frame keeps old weights.
        do_reset();
        rst           = 1'b1;
        bus.din_r     = 16'h4000;
        bus.din_i     = 16'h0000;
        bus.din_valid = 1'b1;
        tick();
        wait_cnt(3);
        bus.w_we     = 1'b1;
        bus.w_commit = 1'b1;
        bus.w_addr   = 2'd0;
        bus.w_re     = 16'h0000;
        bus.w_im     = 16'h4000;
        tick();
        bus.w_we     = 1'b0;
        bus.w_commit = 1'b0;
        wait_dv(lat);
        check("midcommit old y1r", 32'(yr[0]), 32'h2000);
        check("midcommit old y1i", 32'(yi[0]), 32'h0000);
        wait_dv(lat);
        check("midcommit new y1r", 32'(yr[0]), 32'h0000);
        check("midcommit new y1i", 32'(yi[0]), 32'h2000);
        check("midcommit new y2r", 32'(yr[1]), 32'h2000);

        // Invalid symbol: no strobe, outputs hold.
        bus.din_valid = 1'b0;
        bus.din_r     = 16'h7123;
        dv_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.dout_valid === 1'b1) dv_cnt++;
        end
        check("hold no strobe", 32'(dv_cnt), 32'd0);
        check("hold y1r", 32'(yr[0]), 32'h0000);
        check("hold y1i", 32'(yi[0]), 32'h2000);

        // Reset in the middle of a frame.
        bus.din_r     = 16'h7FFF;
        bus.din_i     = 16'h0000;
        bus.din_valid = 1'b1;
        wait_cnt(4);
        rst = 1'b0;
        tick();
        check("midrst y1r", 32'(yr[0]), 32'd0);
        check("midrst y1i", 32'(yi[0]), 32'd0);
        check("midrst dout_valid", 32'(bus.dout_valid), 32'd0);
        bus.din_valid = 1'b0;
        rst = 1'b1;
        dv_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (bus.dout_valid === 1'b1) dv_cnt++;
        end
        check("midrst stray strobe", 32'(dv_cnt), 32'd0);
        wait_cnt(0);
        bus.din_r     = 16'h4000;
        bus.din_i     = 16'h0000;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        wait_dv(lat);
        check("midrst default y1r", 32'(yr[0]), 32'h2000);
        check("midrst default y1i", 32'(yi[0]), 32'h0000);

        tick();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
